// File: rtl/case_4_accum_pkg.sv
// case_4 product accumulator: shared types and clamp limits.
`timescale 1ns/1ps
package case_4_accum_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ACC = 1'b0;
  localparam state_t OUT = 1'b1;

  function automatic int acc_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int acc_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/case_4_prod_accum_if.sv
// case_4 product accumulator: product-in / block-sum-out handshakes.
`timescale 1ns/1ps
interface case_4_prod_accum_if #(
  parameter int DIN_WIDTH = 10,
  parameter int ACC_WIDTH = 16
);

  logic signed [DIN_WIDTH-1:0] s_data;
  logic                        s_valid;
  logic                        s_ready;
  logic signed [ACC_WIDTH-1:0] m_data;
  logic                        m_sat;
  logic                        m_valid;
  logic                        m_ready;

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready,
    output m_data,
    output m_sat,
    output m_valid,
    input  m_ready
  );

  modport master (
    output s_data,
    output s_valid,
    input  s_ready,
    input  m_data,
    input  m_sat,
    input  m_valid,
    output m_ready
  );

endinterface

// File: rtl/case_4_sat_add.sv
// case_4 product accumulator: sign-extending add with clamp.
`timescale 1ns/1ps
module case_4_sat_add
  import case_4_accum_pkg::*;
#(
  parameter int DIN_WIDTH = 10,
  parameter int ACC_WIDTH = 16
) (
  input  logic signed [ACC_WIDTH-1:0] a,
  input  logic signed [DIN_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0] sum,
  output logic                        sat
);

  localparam int MAXI = acc_max(ACC_WIDTH);
  localparam int MINI = acc_min(ACC_WIDTH);
  localparam logic signed [ACC_WIDTH-1:0] MAXV =
    ACC_WIDTH'(MAXI);
  localparam logic signed [ACC_WIDTH-1:0] MINV =
    ACC_WIDTH'(MINI);
  localparam int EXT = ACC_WIDTH + 1 - DIN_WIDTH;

  logic signed [ACC_WIDTH:0] full;
  logic                      ovf_hi;
  logic                      ovf_lo;

  // One guard bit is enough: both operands fit in ACC_WIDTH bits.
  assign full = {a[ACC_WIDTH-1], a}
              + {{EXT{b[DIN_WIDTH-1]}}, b};

  assign ovf_hi = full[ACC_WIDTH:ACC_WIDTH-1] == 2'b01;
  assign ovf_lo = full[ACC_WIDTH:ACC_WIDTH-1] == 2'b10;

  always_comb begin
    sum = full[ACC_WIDTH-1:0];
    sat = 1'b0;
    unique case (1'b1)
      ovf_hi: begin
        sum = MAXV;
        sat = 1'b1;
      end
      ovf_lo: begin
        sum = MINV;
        sat = 1'b1;
      end
      default: begin
        sum = full[ACC_WIDTH-1:0];
        sat = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/case_4_prod_accum.sv
// case_4 product accumulator: sums LEN signed products per block
// into a saturating accumulator and emits each block sum.
`timescale 1ns/1ps
module case_4_prod_accum
  import case_4_accum_pkg::*;
#(
  parameter int DIN_WIDTH = 10,
  parameter int ACC_WIDTH = 16,
  parameter int LEN       = 8,
  parameter int CNT_WIDTH = $clog2(LEN) + 1
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 clr,
  case_4_prod_accum_if.slave   io,
  output logic                 busy
);

  state_t                      state;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] sum;
  logic [CNT_WIDTH-1:0]        cnt;
  logic                        flag;
  logic                        sat;
  logic                        beat;
  logic                        last;

  // acc and cnt are already zero in OUT, so a beat taken on the
  // releasing cycle naturally starts the next block.
  case_4_sat_add #(
    .DIN_WIDTH (DIN_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_add (
    .a   (acc),
    .b   (io.s_data),
    .sum (sum),
    .sat (sat)
  );

  assign io.s_ready = ap_rst_n && !clr
                   && (state == ACC || io.m_ready);
  assign beat = io.s_valid && io.s_ready;
  assign last = cnt == CNT_WIDTH'(LEN - 1);
  assign busy = (cnt != '0) || io.m_valid;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= ACC;
      acc        <= '0;
      cnt        <= '0;
      flag       <= 1'b0;
      io.m_data  <= '0;
      io.m_sat   <= 1'b0;
      io.m_valid <= 1'b0;
    end else if (clr) begin
      state      <= ACC;
      acc        <= '0;
      cnt        <= '0;
      flag       <= 1'b0;
      io.m_valid <= 1'b0;
    end else begin
      if (state == OUT && io.m_ready) begin
        state      <= ACC;
        io.m_valid <= 1'b0;
      end
      if (beat) begin
        if (last) begin
          io.m_data  <= sum;
          io.m_sat   <= flag | sat;
          io.m_valid <= 1'b1;
          state      <= OUT;
          acc        <= '0;
          cnt        <= '0;
          flag       <= 1'b0;
        end else begin
          acc  <= sum;
          cnt  <= cnt + CNT_WIDTH'(1);
          flag <= flag | sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_case_4_prod_accum.sv
// Scoreboard bench for case_4_prod_accum with a behavioural block-sum model.
`timescale 1ns/1ps
module tb_case_4_prod_accum;

  localparam int DW   = 10;
  localparam int AW   = 12;
  localparam int LEN  = 8;
  localparam int AMAX = (1 << (AW - 1)) - 1;
  localparam int AMIN = -(1 << (AW - 1));

  typedef struct {
    int sum;
    bit sat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;
  logic busy;
  bit   rnd_mode = 1'b0;
  bit   mr_dir   = 1'b1;
  bit   mr_rand  = 1'b1;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_out    = 0;
  int   m_acc    = 0;
  int   m_cnt    = 0;
  bit   m_flag   = 1'b0;

  case_4_prod_accum_if #(.DIN_WIDTH(DW), .ACC_WIDTH(AW)) io ();

  assign io.m_ready = rnd_mode ? mr_rand : mr_dir;

  case_4_prod_accum #(
    .DIN_WIDTH (DW),
    .ACC_WIDTH (AW),
    .LEN       (LEN)
  ) dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .clr      (clr),
    .io       (io),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    m_acc  = 0;
    m_cnt  = 0;
    m_flag = 1'b0;
  endfunction

  // Block sum with clamping applied after every product.
  function automatic void model_beat(input int d);
    exp_t e;
    m_acc = m_acc + d;
    if (m_acc > AMAX) begin
      m_acc  = AMAX;
      m_flag = 1'b1;
    end else if (m_acc < AMIN) begin
      m_acc  = AMIN;
      m_flag = 1'b1;
    end
    m_cnt++;
    if (m_cnt == LEN) begin
      e.sum = m_acc;
      e.sat = m_flag;
      q.push_back(e);
      model_clear();
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int d);
    bit ok;
    ok = 1'b0;
    io.s_valid = 1'b1;
    io.s_data  = DW'(d);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = io.s_ready;
      @(posedge clk);
      #1;
    end
    io.s_valid = 1'b0;
    if (ok) begin
      model_beat(d);
    end else begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got no s_ready expected accept of %0d", d);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && !clr && io.m_valid && io.m_ready) begin
      n_out++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got %0d expected no output",
                 io.m_data);
      end else begin
        e = q.pop_front();
        chk("m_data", io.m_data, e.sum);
        chk("m_sat", io.m_sat, e.sat);
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_mode) begin
      #1;
      mr_rand = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    io.s_valid = 1'b0;
    io.s_data  = '0;
    mr_dir     = 1'b1;

    #12;
    chk("rst_m_valid", io.m_valid, 0);
    chk("rst_m_data", io.m_data, 0);
    chk("rst_m_sat", io.m_sat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", io.s_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    n0 = n_out;
    repeat (LEN) send(5);
    chk("t1_latency", io.m_valid, 1);
    idle(3);
    chk("t1_count", n_out - n0, 1);

    repeat (LEN) send(511);
    repeat (LEN) send(-512);
    idle(3);

    mr_dir = 1'b0;
    repeat (LEN) send(10);
    repeat (5) begin
      @(negedge clk);
      chk("t3_valid", io.m_valid, 1);
      chk("t3_hold", io.m_data, 80);
      chk("t3_s_ready", io.s_ready, 0);
    end
    @(posedge clk);
    #1;
    mr_dir     = 1'b1;
    io.s_valid = 1'b1;
    io.s_data  = DW'(3);
    @(negedge clk);
    chk("t3_same_cycle_ready", io.s_ready, 1);
    @(posedge clk);
    #1;
    model_beat(3);
    io.s_valid = 1'b0;
    chk("t3_m_valid_clear", io.m_valid, 0);
    chk("t3_busy", busy, 1);
    repeat (LEN - 1) send(1);
    idle(3);

    repeat (3) send(7);
    clr        = 1'b1;
    io.s_valid = 1'b1;
    io.s_data  = DW'(99);
    @(negedge clk);
    chk("t4_clr_s_ready", io.s_ready, 0);
    @(posedge clk);
    #1;
    clr        = 1'b0;
    io.s_valid = 1'b0;
    model_clear();
    chk("t4_busy", busy, 0);
    chk("t4_m_valid", io.m_valid, 0);
    repeat (LEN) send(1);
    idle(3);

    repeat (4) send(100);
    chk("t5_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_m_valid", io.m_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_s_ready", io.s_ready, 0);
    chk("t5_m_data", io.m_data, 0);
    model_clear();
    idle(2);
    rst_n = 1'b1;
    idle(1);
    repeat (LEN) send(-2);
    idle(3);

    n0 = n_out;
    for (int i = 0; i < LEN; i++) begin
      idle($urandom_range(0, 3));
      if (i == LEN - 1) chk("t6_no_early", io.m_valid, 0);
      send(9);
    end
    chk("t6_latency", io.m_valid, 1);
    idle(3);
    chk("t6_count", n_out - n0, 1);

    rnd_mode = 1'b1;
    repeat (300) begin
      idle($urandom_range(0, 2));
      send(int'($urandom_range(0, 1023)) - 512);
    end
    rnd_mode = 1'b0;
    idle(1);
    mr_dir = 1'b1;
    idle(10);
    chk("drain_queue", q.size(), 0);
    chk("partial_busy", busy, (m_cnt != 0) ? 1 : 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
